// File: rtl/uart_tx_ser.sv
// UART transmit serializer: start / DATALEN data bits (LSB first) / optional parity / stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit; PARITY_ODD selects odd parity in that build.
module uart_tx_ser #(
    parameter int DATALEN    = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [DATALEN-1:0] tx_data,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               tx
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam int IDX_W   = $clog2(DATALEN);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               stop_idx;
    logic [DATALEN-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic               par;
`endif

    logic bit_end;
    assign bit_end = (cnt == CNT_W'(BIT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE)
                cnt <= bit_end ? '0 : cnt + 1'b1;

            // tx is registered, so each branch loads the level of the bit that starts next cycle
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        shreg   <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par     <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                        cnt     <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == IDX_W'(DATALEN - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            tx       <= par;
`else
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
